// File: rtl/rpn_stack_sequencer_if.sv
// Token, result/error and stack-store signals between the RPN sequencer and its neighbours.
// master = token source / stack side, slave = rpn_stack_sequencer.
interface rpn_stack_sequencer_if #(
  parameter int data_width = 4
);
  logic                  tok_valid;
  logic                  tok_ready;
  logic                  tok_is_op;
  logic [data_width-1:0] tok_data;
  logic [data_width-1:0] result;
  logic                  result_valid;
  logic                  err_valid;
  logic [1:0]            err_code;
  logic                  stk_push;
  logic                  stk_pop;
  logic                  stk_peak;
  logic [data_width-1:0] stk_dataIn;
  logic [data_width-1:0] stk_dataOut;

  modport master (
    output tok_valid, tok_is_op, tok_data, stk_dataOut,
    input  tok_ready, result, result_valid, err_valid, err_code,
    input  stk_push, stk_pop, stk_peak, stk_dataIn
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_data, stk_dataOut,
    output tok_ready, result, result_valid, err_valid, err_code,
    output stk_push, stk_pop, stk_peak, stk_dataIn
  );
endinterface

// File: rtl/rpn_stack_sequencer.sv
// RPN calculator front end: accepts tokens, sequences the stack store, computes results.
// Define RPN_DIV_EN to make opcode 11 an unsigned divide instead of an illegal opcode.
module rpn_stack_sequencer #(
  parameter int data_width  = 4,
  parameter int STACK_depth = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  rpn_stack_sequencer_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_depth + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_depth);

  localparam logic [2:0] S_DRAIN  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_PUSH   = 3'd2;
  localparam logic [2:0] S_POP_B  = 3'd3;
  localparam logic [2:0] S_POP_A  = 3'd4;
  localparam logic [2:0] S_CAP_A  = 3'd5;
  localparam logic [2:0] S_PUSH_R = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]            r_state;
  logic [DEPTH_W-1:0]    r_drain_cnt;
  logic [DEPTH_W-1:0]    r_depth;
  logic [1:0]            r_op;
  logic [data_width-1:0] r_b;
  logic [data_width-1:0] r_result;
  logic [data_width-1:0] r_stk_dataIn;
  logic                  r_tok_ready;
  logic                  r_stk_push;
  logic                  r_stk_pop;
  logic                  r_result_valid;
  logic                  r_err_valid;
  logic [1:0]            r_err_code;

  logic [2:0]            w_state_next;
  logic                  w_accept;
  logic                  w_op_illegal;
  logic                  w_err_fire;
  logic [1:0]            w_err_code_next;
  logic [data_width-1:0] w_a;
  logic [data_width-1:0] w_alu;

  assign w_accept = r_tok_ready & bus.tok_valid;
  assign w_a      = bus.stk_dataOut;

`ifdef RPN_DIV_EN
  assign w_op_illegal = 1'b0;
`else
  assign w_op_illegal = (bus.tok_data[1:0] == 2'b11);
`endif

  // A is the deeper operand, read back the cycle after its pop; B was captured one cycle earlier.
  always_comb begin
    w_alu = '0;
    case (r_op)
      2'b00:   w_alu = w_a + r_b;
      2'b01:   w_alu = w_a - r_b;
      2'b10:   w_alu = w_a * r_b;
`ifdef RPN_DIV_EN
      default: w_alu = (r_b == '0) ? '1 : w_a / r_b;
`else
      default: w_alu = '0;
`endif
    endcase
  end

  always_comb begin
    w_state_next    = r_state;
    w_err_fire      = 1'b0;
    w_err_code_next = r_err_code;
    case (r_state)
      S_DRAIN: if (r_drain_cnt == DEPTH_MAX) w_state_next = S_IDLE;
      S_IDLE: begin
        if (w_accept) begin
          if (!bus.tok_is_op) begin
            if (r_depth == DEPTH_MAX) begin
              w_state_next    = S_ERR;
              w_err_fire      = 1'b1;
              w_err_code_next = 2'b01;
            end else begin
              w_state_next = S_PUSH;
            end
          end else if (r_depth < DEPTH_W'(2)) begin
            w_state_next    = S_ERR;
            w_err_fire      = 1'b1;
            w_err_code_next = 2'b10;
          end else if (w_op_illegal) begin
            w_state_next    = S_ERR;
            w_err_fire      = 1'b1;
            w_err_code_next = 2'b11;
          end else begin
            w_state_next = S_POP_B;
          end
        end
      end
      S_PUSH:  w_state_next = S_IDLE;
      S_POP_B: w_state_next = S_POP_A;
      S_POP_A: w_state_next = S_CAP_A;
      S_CAP_A: begin
        w_state_next = S_PUSH_R;
`ifdef RPN_DIV_EN
        // Divide by zero still pushes a result; the error rides along in the same cycle.
        if (r_op == 2'b11 && r_b == '0) begin
          w_err_fire      = 1'b1;
          w_err_code_next = 2'b11;
        end
`endif
      end
      S_PUSH_R: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so every output is 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_DRAIN;
      r_drain_cnt    <= '0;
      r_depth        <= '0;
      r_op           <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_stk_dataIn   <= '0;
      r_tok_ready    <= 1'b0;
      r_stk_push     <= 1'b0;
      r_stk_pop      <= 1'b0;
      r_result_valid <= 1'b0;
      r_err_valid    <= 1'b0;
      r_err_code     <= '0;
    end else begin
      r_state        <= w_state_next;
      r_drain_cnt    <= (w_state_next == S_DRAIN) ? r_drain_cnt + DEPTH_W'(1) : '0;
      r_tok_ready    <= (w_state_next == S_IDLE);
      r_stk_pop      <= (w_state_next inside {S_DRAIN, S_POP_B, S_POP_A});
      r_stk_push     <= (w_state_next inside {S_PUSH, S_PUSH_R});
      r_result_valid <= (w_state_next == S_PUSH_R);
      r_err_valid    <= w_err_fire;
      if (w_err_fire) r_err_code <= w_err_code_next;

      if (w_accept && bus.tok_is_op) r_op <= bus.tok_data[1:0];
      if (w_state_next == S_PUSH && r_state == S_IDLE) begin
        r_stk_dataIn <= bus.tok_data;
        r_depth      <= r_depth + DEPTH_W'(1);
      end
      if (r_state == S_POP_A) r_b <= bus.stk_dataOut;
      if (r_state == S_CAP_A) begin
        r_result     <= w_alu;
        r_stk_dataIn <= w_alu;
        r_depth      <= r_depth - DEPTH_W'(1);
      end
    end
  end

  assign bus.tok_ready    = r_tok_ready;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.err_valid    = r_err_valid;
  assign bus.err_code     = r_err_code;
  assign bus.stk_push     = r_stk_push;
  assign bus.stk_pop      = r_stk_pop;
  assign bus.stk_peak     = 1'b0;
  assign bus.stk_dataIn   = r_stk_dataIn;
endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Self-checking bench for rpn_stack_sequencer with a behavioural stack store and an event scoreboard.
// Honours RPN_DIV_EN the same way as the design.
module tb_rpn_stack_sequencer;
  localparam int DW = 4;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rpn_stack_sequencer_if #(.data_width(DW)) tb_if ();

  rpn_stack_sequencer #(.data_width(DW), .STACK_depth(SD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (tb_if)
  );

  // Stack store without reset: starts with leftover contents the drain must clear.
  logic [DW-1:0] stk_mem [SD] = '{4'h3, 4'hC, 4'h5, 4'h9};
  int            stk_sp = 3;
  always @(posedge clk) begin
    if (tb_if.stk_push && stk_sp < SD) begin
      stk_mem[stk_sp] <= tb_if.stk_dataIn;
      stk_sp          <= stk_sp + 1;
    end else if (tb_if.stk_pop && stk_sp > 0) begin
      tb_if.stk_dataOut <= stk_mem[stk_sp-1];
      stk_sp            <= stk_sp - 1;
    end
  end

  typedef struct packed {
    logic          rv;
    logic          ev;
    logic [DW-1:0] res;
    logic [1:0]    code;
  } ev_t;

  ev_t           sb_q[$];
  logic [DW-1:0] mdl_stk[$];
  logic [DW-1:0] last_result = '0;
  logic [1:0]    last_code   = '0;
  int            n_checks = 0;
  int            n_fail   = 0;
  ev_t           mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (tb_if.stk_push || tb_if.stk_pop))
      check_eq("push_pop_excl", 32'(tb_if.stk_push & tb_if.stk_pop), 32'(0));
    if (rst_n && (tb_if.result_valid || tb_if.err_valid)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_event", 32'({tb_if.result_valid, tb_if.err_valid}), 32'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("event_kind", 32'({tb_if.result_valid, tb_if.err_valid}), 32'({mon_e.rv, mon_e.ev}));
        if (mon_e.rv) begin
          check_eq("result", 32'(tb_if.result), 32'(mon_e.res));
          check_eq("push_data", 32'(tb_if.stk_dataIn), 32'(mon_e.res));
          check_eq("push_with_result", 32'(tb_if.stk_push), 32'(1));
        end
        if (mon_e.ev) check_eq("err_code", 32'(tb_if.err_code), 32'(mon_e.code));
      end
    end
  end

  // Reference model: predicts the event (if any), stack activity and latency for one token.
  task automatic model_tok(input logic is_op, input logic [DW-1:0] d,
                           output int exp_push, output int exp_pop, output int exp_lat);
    ev_t           e;
    logic [DW-1:0] a, b, r;
    logic [1:0]    opc;
    e = '0; exp_push = 0; exp_pop = 0; exp_lat = 1;
    opc = d[1:0];
    if (!is_op) begin
      if (mdl_stk.size() == SD) begin
        e.ev = 1'b1; e.code = 2'b01;
      end else begin
        mdl_stk.push_back(d);
        exp_push = 1;
      end
    end else if (mdl_stk.size() < 2) begin
      e.ev = 1'b1; e.code = 2'b10;
`ifndef RPN_DIV_EN
    end else if (opc == 2'b11) begin
      e.ev = 1'b1; e.code = 2'b11;
`endif
    end else begin
      b = mdl_stk.pop_back();
      a = mdl_stk.pop_back();
      case (opc)
        2'b00:   r = a + b;
        2'b01:   r = a - b;
        2'b10:   r = a * b;
        default: begin
          if (b == '0) begin
            r = '1; e.ev = 1'b1; e.code = 2'b11;
          end else begin
            r = a / b;
          end
        end
      endcase
      mdl_stk.push_back(r);
      e.rv = 1'b1; e.res = r;
      last_result = r;
      exp_push = 1; exp_pop = 2; exp_lat = 4;
    end
    if (e.ev) last_code = e.code;
    if (e.rv || e.ev) sb_q.push_back(e);
  endtask

  task automatic send_tok(input logic is_op, input logic [DW-1:0] d);
    int ep, eo, el, lat, np, no, w;
    model_tok(is_op, d, ep, eo, el);
    w = 0;
    while (!tb_if.tok_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check_eq("ready_before_token", 32'(tb_if.tok_ready), 32'(1));
    tb_if.tok_is_op = is_op;
    tb_if.tok_data  = d;
    tb_if.tok_valid = 1'b1;
    @(posedge clk); #1;
    tb_if.tok_valid = 1'b0;
    lat = 0; np = 0; no = 0;
    while (!tb_if.tok_ready && lat < 20) begin
      np += int'(tb_if.stk_push);
      no += int'(tb_if.stk_pop);
      @(posedge clk); #1; lat++;
    end
    check_eq("latency", 32'(lat), 32'(el));
    check_eq("push_count", 32'(np), 32'(ep));
    check_eq("pop_count", 32'(no), 32'(eo));
    $display("token op=%0d data=0x%0h lat=%0d pushes=%0d pops=%0d result=0x%0h err_code=%0d",
             is_op, d, lat, np, no, tb_if.result, tb_if.err_code);
  endtask

  task automatic do_reset();
    int pops, first_rdy, overlap;
    @(negedge clk);
    rst_n = 1'b0;
    tb_if.tok_valid = 1'b0;
    mdl_stk.delete();
    sb_q.delete();
    last_result = '0;
    last_code   = '0;
    @(negedge clk);
    check_eq("reset_outputs",
             32'({tb_if.tok_ready, tb_if.stk_push, tb_if.stk_pop, tb_if.stk_peak, tb_if.stk_dataIn,
                  tb_if.result, tb_if.result_valid, tb_if.err_valid, tb_if.err_code}), 32'(0));
    rst_n = 1'b1;
    pops = 0; first_rdy = 0; overlap = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (tb_if.stk_pop) pops++;
      if (tb_if.tok_ready && first_rdy == 0) first_rdy = i;
      if (tb_if.tok_ready && tb_if.stk_pop) overlap++;
    end
    check_eq("drain_pops", 32'(pops), 32'(SD));
    check_eq("drain_ready_cycle", 32'(first_rdy), 32'(SD + 1));
    check_eq("drain_ready_pop_overlap", 32'(overlap), 32'(0));
    $display("reset drain pops=%0d ready_at_cycle=%0d", pops, first_rdy);
  endtask

  initial begin
    int w;
    tb_if.tok_valid = 1'b0;
    tb_if.tok_is_op = 1'b0;
    tb_if.tok_data  = '0;

    do_reset();
    send_tok(1'b0, 4'd3);
    send_tok(1'b0, 4'd5);
    send_tok(1'b1, 4'd1);
    check_eq("sub_result", 32'(tb_if.result), 32'(4'hE));
    send_tok(1'b0, 4'd7);
    send_tok(1'b0, 4'd6);
    send_tok(1'b1, 4'd2);
    check_eq("mul_result", 32'(tb_if.result), 32'(4'hA));
    send_tok(1'b0, 4'd1);
    send_tok(1'b1, 4'd0);
    check_eq("add_result", 32'(tb_if.result), 32'(4'hB));

    do_reset();
    for (int i = 1; i <= 4; i++) send_tok(1'b0, 4'(i));
    send_tok(1'b0, 4'd9);
    repeat (3) send_tok(1'b1, 4'd0);
    check_eq("overflow_chain_result", 32'(tb_if.result), 32'(4'hA));

    do_reset();
    send_tok(1'b0, 4'd2);
    send_tok(1'b1, 4'd0);
`ifdef RPN_DIV_EN
    do_reset();
    send_tok(1'b0, 4'd9);
    send_tok(1'b0, 4'd2);
    send_tok(1'b1, 4'd3);
    check_eq("div_result", 32'(tb_if.result), 32'(4'd4));
    send_tok(1'b0, 4'd0);
    send_tok(1'b1, 4'd3);
    check_eq("div0_result", 32'(tb_if.result), 32'(4'hF));
`else
    send_tok(1'b0, 4'd5);
    send_tok(1'b1, 4'd3);
    check_eq("illegal_code", 32'(tb_if.err_code), 32'(2'b11));
`endif

    // Abort an operator mid-flight; depth must restart at zero.
    do_reset();
    send_tok(1'b0, 4'd1);
    send_tok(1'b0, 4'd2);
    tb_if.tok_is_op = 1'b1;
    tb_if.tok_data  = 4'd0;
    tb_if.tok_valid = 1'b1;
    @(posedge clk); #1;
    tb_if.tok_valid = 1'b0;
    @(posedge clk); #1;
    do_reset();
    send_tok(1'b0, 4'd2);
    send_tok(1'b1, 4'd0);

    do_reset();
    repeat (40) send_tok(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    w = 0;
    while (sb_q.size() != 0 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check_eq("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    check_eq("result_hold", 32'(tb_if.result), 32'(last_result));
    check_eq("err_code_hold", 32'(tb_if.err_code), 32'(last_code));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rpn_stack_sequencer.md
Name: rpn_stack_sequencer

Overview:
Command front end for the 4-bit RPN calculator. Accepts operand and operator tokens over a valid/ready handshake and drives the push/pop/peak/dataIn interface of the stack store. Computes binary results and pushes them back onto the stack. Tracks stack depth itself, because the stack reports no full/empty status.

Parameters:
data_width, 4, operand/result width; must match the stack store
STACK_depth, 4, stack entries; must match the stack store

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
tok_valid  in  1  token offered
tok_ready  out  1  sequencer can accept a token this cycle
tok_is_op  in  1  1 = operator, 0 = operand
tok_data  in  data_width  operand value, or opcode in bits [1:0]
result  out  data_width  last computed result
result_valid  out  1  one-cycle pulse when result is pushed
err_valid  out  1  one-cycle error pulse
err_code  out  2  01 overflow, 10 underflow, 11 illegal op / divide-by-zero
stk_push  out  1  to stack push
stk_pop  out  1  to stack pop
stk_peak  out  1  to stack peak; held 0
stk_dataIn  out  data_width  to stack dataIn
stk_dataOut  in  data_width  from stack dataOut; valid the cycle after stk_pop is sampled

Behaviour:
- Reset (rst_n low, async):
  - State = DRAIN, drain counter = 0, depth = 0.
  - All outputs 0, including tok_ready, stk_*, result, result_valid, err_valid, err_code.
- DRAIN:
  - The stack has no reset, so after rst_n rises the sequencer holds stk_pop=1 for exactly STACK_depth cycles, with tok_ready=0.
  - It then enters IDLE. Pops on an empty stack are harmless.
- IDLE:
  - tok_ready=1.
  - A token is accepted on a clk edge where tok_valid && tok_ready.
  - tok_ready drops the cycle after acceptance and stays low until the sequence returns to IDLE.
- Operand token:
  - If depth == STACK_depth: err_valid=1, err_code=01 for one cycle. Token is discarded, no push, return to IDLE.
  - Otherwise enter PUSH for one cycle: stk_push=1, stk_dataIn=tok_data, depth+1. Then IDLE.
  - Total: accept cycle plus one cycle.
- Operator token:
  - Opcodes: 00 ADD, 01 SUB, 10 MUL, 11 per the optional feature.
  - If depth < 2: err_code=10 pulse, no stack activity, return to IDLE.
  - If opcode is illegal: err_code=11 pulse, no stack activity, return to IDLE.
  - Otherwise the FSM runs POP_B → POP_A → CAP_A → PUSH_R → IDLE:
    - POP_B: stk_pop=1.
    - POP_A: stk_pop=1; capture B from stk_dataOut.
    - CAP_A: capture A from stk_dataOut; compute the result register.
    - PUSH_R: stk_push=1, stk_dataIn=result, result_valid=1. Net depth change is −1.
  - Operator latency: 4 cycles after acceptance until tok_ready is high again.
- Arithmetic (A is the deeper operand, B was on top), all modulo 2^data_width, unsigned:
  - ADD = A+B.
  - SUB = A−B.
  - MUL = low data_width bits of A*B.
- Output hold rules:
  - result holds its value until the next PUSH_R.
  - err_code holds its value until the next error.
  - err_valid and result_valid never assert in the same cycle.
- Only one of stk_push and stk_pop is high in any cycle.
- depth never exceeds STACK_depth and never goes below 0.
- Reset mid-operation: abort immediately and restart at DRAIN. Stack contents are discarded.

Optional Feature:
- Macro: RPN_DIV_EN.
- Defined: opcode 11 = DIV, A/B unsigned, quotient truncated. If B == 0, both operands are still consumed, all-ones is pushed as the result, and result_valid and err_valid(code 11) pulse in the same PUSH_R cycle. This is the sole exception to the result_valid/err_valid exclusivity rule.
- Not defined: opcode 11 is illegal. It is rejected at acceptance with err_code=11 and no stack activity.

Test Plan:
- Release reset → stk_pop high for exactly 4 cycles with tok_ready=0, then tok_ready=1 and stk_pop=0.
- Push 3, push 5, SUB → stk_pop on 2 consecutive cycles, then stk_push with stk_dataIn=4'hE, result=4'hE, result_valid for one cycle, depth 1.
- Push 7, push 6, MUL → result 4'hA (42 mod 16). Follow with push 1, ADD → result 4'hB.
- Push 1,2,3,4, then push 9 → err_valid, err_code=01, no stk_push on the 5th token, depth stays 4. Then 3×ADD → result 4'hA.
- From empty, push 2, then ADD → err_code=10 with no stk_pop. Without RPN_DIV_EN, opcode 11 → err_code=11.
- With RPN_DIV_EN: push 9, push 2, DIV → result 4. Push 0, DIV → result 4'hF with err_code=11 in the same cycle, depth 1.
